// File: rtl/barrett_const_precompute.sv
// barrett_const_precompute: restoring divider producing floor(2^SHIFT / M), one quotient bit per cycle
module barrett_const_precompute #(
  parameter int N     = 32,
  parameter int SHIFT = 64,
  parameter int CW    = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   m_in,
  output logic           busy,
  output logic           done,
  output logic           valid,
  output logic           err,
  output logic [2*N-1:0] const_out,
  output logic [N-1:0]   m_out
);
  typedef enum logic {IDLE, DIV} state_t;
  state_t         state_q, state_d;
  logic [N:0]     r_q, r_d, r_sh;
  logic [2*N-1:0] q_q, q_d, q_nx, const_q, const_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   m_q, m_d;
  logic           done_q, done_d, valid_q, valid_d, err_q, err_d, ge;
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    const_d = const_q;
    valid_d = valid_q;
    err_d   = err_q;
    done_d  = 1'b0;
    // dividend 2^SHIFT: a single leading one, then SHIFT zero bits
    r_sh    = {r_q[N-1:0], cnt_q == CW'(SHIFT)};
    ge      = r_sh >= {1'b0, m_q};
    q_nx    = {q_q[2*N-2:0], ge};
    if (state_q == IDLE && start) begin
      m_d     = m_in;
      valid_d = 1'b0;
      err_d   = m_in[N-1:1] == '0;
      done_d  = err_d;
      const_d = err_d ? '1 : const_q;
      state_d = err_d ? IDLE : DIV;
      r_d     = '0;
      q_d     = '0;
      cnt_d   = CW'(SHIFT);
    end else if (state_q == DIV) begin
      r_d     = ge ? r_sh - {1'b0, m_q} : r_sh;
      q_d     = q_nx;
      cnt_d   = cnt_q - 1'b1;
      done_d  = cnt_q == '0;
      valid_d = done_d;
      const_d = done_d ? q_nx : const_q;
      state_d = done_d ? IDLE : DIV;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      const_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      const_q <= const_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end
  assign busy      = state_q == DIV;
  assign done      = done_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign const_out = const_q;
  assign m_out     = m_q;
endmodule

// File: tb/tb_barrett_const_precompute.sv
// tb_barrett_const_precompute: directed and random checks against an arithmetic division model
module tb_barrett_const_precompute;
  localparam int N = 32, SHIFT = 64, CW = 7;
  logic          clk = 0, rst = 1, start = 0;
  logic [N-1:0]  m_in = '0;
  logic          busy, done, valid, err;
  logic [2*N-1:0] const_out;
  logic [N-1:0]  m_out;
  int vectors = 0, miscompares = 0;

  barrett_const_precompute #(.N(N), .SHIFT(SHIFT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .m_in(m_in), .busy(busy), .done(done),
    .valid(valid), .err(err), .const_out(const_out), .m_out(m_out));

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] ref_const(input logic [N-1:0] m);
    logic [127:0] num;
    num = 128'd1 << SHIFT;
    if (m < 2) return '1;
    return 64'(num / {96'd0, m});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input logic [N-1:0] m);
    int n;
    logic [2*N-1:0] e;
    e = ref_const(m);
    m_in = m;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(n);
    chk("latency", 64'(n), (m < 2) ? 64'd0 : 64'(SHIFT + 1));
    chk("const", const_out, e);
    chk("m_out", 64'(m_out), 64'(m));
    chk("valid", 64'(valid), 64'(m >= 2));
    chk("err", 64'(err), 64'(m < 2));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("const_hold", const_out, e);
  endtask

  initial begin
    int n, seen;
    logic [N-1:0] dm [7] = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd0, 32'd1, 32'd5};
    logic [63:0]  dc [7] = '{64'h5555_5555_5555_5555, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0000,
                             64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h3333_3333_3333_3333};
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_const", const_out, 0);
    chk("rst_m_out", 64'(m_out), 0);
    for (int i = 0; i < 7; i++) begin
      run(dm[i]);
      chk("plan_const", const_out, dc[i]);
    end
    // a start pulse mid-computation must not disturb the running divide
    m_in = 3;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < SHIFT + 1; i++) begin
      chk("busy_hold", 64'(busy), 1);
      chk("no_early_done", 64'(done), 0);
      start = (i == 9);
      m_in = (i == 9) ? 32'd7 : 32'd3;
      @(negedge clk);
    end
    start = 0;
    chk("ign_done", 64'(done), 1);
    chk("ign_busy", 64'(busy), 0);
    chk("ign_const", const_out, 64'h5555_5555_5555_5555);
    chk("ign_m_out", 64'(m_out), 3);
    @(negedge clk);
    // reset in the middle of a divide aborts it
    m_in = 3;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (29) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_valid", 64'(valid), 0);
    chk("abort_const", const_out, 0);
    chk("abort_m_out", 64'(m_out), 0);
    chk("abort_done", 64'(done), 0);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      seen += int'(done);
    end
    chk("abort_no_done", 64'(seen), 0);
    run(32'd5);
    // held start: one IDLE cycle between back-to-back operations
    m_in = 32'd9;
    start = 1;
    @(negedge clk);
    wait_done(n);
    chk("held_latency", 64'(n), 64'(SHIFT + 1));
    chk("held_const", const_out, ref_const(32'd9));
    chk("held_idle_gap", 64'(busy), 0);
    @(negedge clk);
    chk("held_restart", 64'(busy), 1);
    chk("held_valid_clr", 64'(valid), 0);
    start = 0;
    wait_done(n);
    chk("held_const2", const_out, ref_const(32'd9));
    @(negedge clk);
    for (int k = 0; k < 25; k++) begin
      logic [N-1:0] m;
      m = N'($urandom);
      if (m < 2) m = 2;
      run(m);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
